// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: IFU and LSU share one memory port, one transaction at a time.
// Round-robin on ties; request payloads pass through combinationally from the current owner.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   // instruction fetch
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_req_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [DATA_W-1:0] ifu_resp_rdata,
   // load/store
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_req_addr,
   input  logic              lsu_req_wen,
   input  logic [DATA_W-1:0] lsu_req_wdata,
   input  logic [7:0]        lsu_req_wmask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_resp_rdata,
   // shared memory port
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_wen,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   output logic              mem_resp_ready,
   input  logic [DATA_W-1:0] mem_resp_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_owner_lsu;
   logic   w_owner_nxt;
   logic   r_last_lsu;
   logic   w_last_nxt;
   logic   w_grant_lsu;
   logic   w_owner_resp_ready;

   // LSU wins a tie unless it was the last master served
   assign w_grant_lsu = lsu_req_valid && (!ifu_req_valid || !r_last_lsu);
   assign w_owner_resp_ready = r_owner_lsu ? lsu_resp_ready : ifu_resp_ready;

   assign ifu_resp_rdata = mem_resp_rdata;
   assign lsu_resp_rdata = mem_resp_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_owner_lsu <= 1'b0;
         r_last_lsu  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner_lsu <= w_owner_nxt;
         r_last_lsu  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner_lsu;
      w_last_nxt     = r_last_lsu;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_addr   = '0;
      mem_req_wen    = 1'b0;
      mem_req_wdata  = '0;
      mem_req_wmask  = 8'h00;
      mem_resp_ready = 1'b0;

      case (r_state)
         IDLE: begin
            if (ifu_req_valid || lsu_req_valid) begin
               w_owner_nxt = w_grant_lsu;
               w_state_nxt = REQ;
            end
         end

         REQ: begin
            mem_req_valid = 1'b1;
            if (r_owner_lsu) begin
               mem_req_addr  = lsu_req_addr;
               mem_req_wen   = lsu_req_wen;
               mem_req_wdata = lsu_req_wdata;
               mem_req_wmask = lsu_req_wmask;
               lsu_req_ready = mem_req_ready;
            end else begin
               mem_req_addr  = ifu_req_addr;
               ifu_req_ready = mem_req_ready;
            end
            if (mem_req_ready) begin
               w_state_nxt = RESP;
            end
         end

         RESP: begin
            mem_resp_ready = w_owner_resp_ready;
            if (r_owner_lsu) begin
               lsu_resp_valid = mem_resp_valid;
            end else begin
               ifu_resp_valid = mem_resp_valid;
            end
            if (mem_resp_valid && w_owner_resp_ready) begin
               w_last_nxt  = r_owner_lsu;
               w_state_nxt = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed IFU/LSU traffic against a simple memory slave,
// with expected request/response records queued at issue time and checked by a monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_resp_valid;
   logic        ifu_resp_ready;
   logic [31:0] ifu_resp_rdata;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [31:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [31:0] lsu_req_wdata;
   logic [7:0]  lsu_req_wmask;
   logic        lsu_resp_valid;
   logic        lsu_resp_ready;
   logic [31:0] lsu_resp_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_rdata;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_req_addr   (ifu_req_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_ready (ifu_resp_ready),
      .ifu_resp_rdata (ifu_resp_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_req_addr   (lsu_req_addr),
      .lsu_req_wen    (lsu_req_wen),
      .lsu_req_wdata  (lsu_req_wdata),
      .lsu_req_wmask  (lsu_req_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_ready (lsu_resp_ready),
      .lsu_resp_rdata (lsu_resp_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_rdata (mem_resp_rdata)
   );

   typedef struct packed {
      logic        lsu;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [7:0]  wmask;
   } req_t;

   typedef struct packed {
      logic        lsu;
      logic [31:0] rdata;
   } rsp_t;

   req_t        exp_req_q[$];
   rsp_t        exp_rsp_q[$];
   logic [31:0] mem_rd_q[$];
   int          hs_cyc_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_req_hs = 0;
   int          n_resp_hs = 0;
   int          cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] outs();
      return {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
              mem_req_valid, mem_resp_ready};
   endfunction

   // Memory slave: accepts a request, then presents the next queued read word until taken
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_resp_valid <= 1'b0;
         mem_resp_rdata <= 32'h0;
      end else begin
         if (mem_resp_valid && mem_resp_ready) mem_resp_valid <= 1'b0;
         if (mem_req_valid && mem_req_ready) begin
            mem_resp_valid <= 1'b1;
            if (mem_rd_q.size() != 0) mem_resp_rdata <= mem_rd_q.pop_front();
            else                      mem_resp_rdata <= 32'hBAD0BAD0;
         end
      end
   end

   // Monitor: every handshake must match the head of the corresponding expectation queue
   always @(negedge clk) begin
      req_t e;
      rsp_t r;
      if (rst_n) begin
         if (mem_req_valid && mem_req_ready) begin
            n_req_hs++;
            hs_cyc_q.push_back(cyc);
            if (exp_req_q.size() == 0) begin
               chk("unexpected_mem_req", {32'h0, mem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_req_q.pop_front();
               chk("req_owner_ready", {62'h0, lsu_req_ready, ifu_req_ready},
                   e.lsu ? 64'h2 : 64'h1);
               chk("req_addr", mem_req_addr, e.addr);
               chk("req_wen", mem_req_wen, e.wen);
               chk("req_wdata", mem_req_wdata, e.wdata);
               chk("req_wmask", mem_req_wmask, e.wmask);
            end
         end
         if (ifu_resp_valid && lsu_resp_valid) chk("both_resp_valid", 1, 0);
         if ((ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready)) begin
            n_resp_hs++;
            if (exp_rsp_q.size() == 0) begin
               chk("unexpected_resp", {63'h0, lsu_resp_valid}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               r = exp_rsp_q.pop_front();
               chk("resp_owner", {63'h0, lsu_resp_valid}, {63'h0, r.lsu});
               chk("resp_rdata", r.lsu ? lsu_resp_rdata : ifu_resp_rdata, r.rdata);
            end
         end
      end
   end

   task automatic ifu_issue(input logic [31:0] a);
      @(posedge clk); #1;
      ifu_req_valid = 1'b1;
      ifu_req_addr  = a;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (ifu_req_ready) begin
            @(posedge clk); #1;
            ifu_req_valid = 1'b0;
            return;
         end
      end
      chk("ifu_req_timeout", 1, 0);
      ifu_req_valid = 1'b0;
   endtask

   task automatic lsu_issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [7:0] m);
      @(posedge clk); #1;
      lsu_req_valid = 1'b1;
      lsu_req_addr  = a;
      lsu_req_wen   = w;
      lsu_req_wdata = d;
      lsu_req_wmask = m;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (lsu_req_ready) begin
            @(posedge clk); #1;
            lsu_req_valid = 1'b0;
            return;
         end
      end
      chk("lsu_req_timeout", 1, 0);
      lsu_req_valid = 1'b0;
   endtask

   task automatic expect_tx(input logic lsu, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [7:0] m, input logic [31:0] rd);
      exp_req_q.push_back('{lsu: lsu, addr: a, wen: w, wdata: d, wmask: m});
      exp_rsp_q.push_back('{lsu: lsu, rdata: rd});
      mem_rd_q.push_back(rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 200000", $time);
      $fatal(1);
   end

   initial begin
      int base;
      int req0;
      int rsp0;
      rst_n          = 1'b0;
      ifu_req_valid  = 1'b0;
      ifu_req_addr   = 32'h0;
      ifu_resp_ready = 1'b1;
      lsu_req_valid  = 1'b0;
      lsu_req_addr   = 32'h0;
      lsu_req_wen    = 1'b0;
      lsu_req_wdata  = 32'h0;
      lsu_req_wmask  = 8'h00;
      lsu_resp_ready = 1'b1;
      mem_req_ready  = 1'b1;

      // Reset: outputs stay at IDLE values even with both requests raised
      repeat (2) @(posedge clk); #1;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      @(negedge clk);
      chk("reset_outs", outs(), 6'b0);
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // IFU-only read with cycle-accurate timing
      expect_tx(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 32'h0000_0413);
      @(posedge clk); #1;
      ifu_req_valid = 1'b1;
      ifu_req_addr  = 32'h8000_0000;
      @(negedge clk);
      chk("c0_idle_outs", outs(), 6'b0);
      @(negedge clk);
      chk("c1_mem_req_valid", mem_req_valid, 1'b1);
      chk("c1_ifu_req_ready", ifu_req_ready, 1'b1);
      chk("c1_mem_req_addr", mem_req_addr, 32'h8000_0000);
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      @(negedge clk);
      chk("c2_ifu_resp_valid", ifu_resp_valid, 1'b1);
      chk("c2_ifu_resp_rdata", ifu_resp_rdata, 32'h0000_0413);
      chk("c2_lsu_outs", {lsu_req_ready, lsu_resp_valid, mem_req_valid}, 3'b000);
      @(negedge clk);
      chk("c3_idle_outs", outs(), 6'b0);

      // Tie after reset: LSU first
      expect_tx(1'b1, 32'h1000_0010, 1'b0, 32'h0, 8'h00, 32'h1111_1111);
      expect_tx(1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h00, 32'h2222_2222);
      fork
         ifu_issue(32'h8000_0004);
         lsu_issue(32'h1000_0010, 1'b0, 32'h0, 8'h00);
      join
      repeat (3) @(posedge clk);

      // Continuous contention: LSU, IFU, LSU, IFU at one access per 3 cycles
      expect_tx(1'b1, 32'h1000_0020, 1'b0, 32'h0, 8'h00, 32'hA000_0001);
      expect_tx(1'b0, 32'h8000_0008, 1'b0, 32'h0, 8'h00, 32'hA000_0002);
      expect_tx(1'b1, 32'h1000_0024, 1'b0, 32'h0, 8'h00, 32'hA000_0003);
      expect_tx(1'b0, 32'h8000_000C, 1'b0, 32'h0, 8'h00, 32'hA000_0004);
      base = hs_cyc_q.size();
      fork
         begin
            lsu_issue(32'h1000_0020, 1'b0, 32'h0, 8'h00);
            lsu_issue(32'h1000_0024, 1'b0, 32'h0, 8'h00);
         end
         begin
            ifu_issue(32'h8000_0008);
            ifu_issue(32'h8000_000C);
         end
      join
      chk("contention_hs_count", hs_cyc_q.size() - base, 4);
      if (hs_cyc_q.size() >= base + 4) begin
         for (int k = 0; k < 3; k++)
            chk("throughput_spacing", hs_cyc_q[base+k+1] - hs_cyc_q[base+k], 3);
      end
      repeat (3) @(posedge clk);

      // Store forwarded intact; following IFU grant carries no write fields
      expect_tx(1'b1, 32'h1000_0040, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'h0);
      expect_tx(1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 32'h3333_3333);
      lsu_issue(32'h1000_0040, 1'b1, 32'hDEAD_BEEF, 8'h0F);
      ifu_issue(32'h8000_0010);
      repeat (3) @(posedge clk);

      // Backpressure on both request and response channels
      expect_tx(1'b0, 32'h8000_0020, 1'b0, 32'h0, 8'h00, 32'h4444_4444);
      req0 = n_req_hs;
      rsp0 = n_resp_hs;
      @(posedge clk); #1;
      mem_req_ready  = 1'b0;
      ifu_resp_ready = 1'b0;
      ifu_req_valid  = 1'b1;
      ifu_req_addr   = 32'h8000_0020;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_req_held", {mem_req_valid, ifu_req_ready, ifu_resp_valid}, 3'b100);
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      ifu_req_valid = 1'b0;
      repeat (3) begin
         chk("bp_resp_held", {ifu_resp_valid, mem_resp_ready, mem_req_valid}, 3'b100);
         @(posedge clk); #1;
      end
      ifu_resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_back_idle", outs(), 6'b0);
      chk("bp_req_hs_count", n_req_hs - req0, 1);
      chk("bp_resp_hs_count", n_resp_hs - rsp0, 1);
      repeat (2) @(posedge clk);

      // Reset during RESP after an LSU win: response dropped, next tie goes to LSU
      expect_tx(1'b1, 32'h1000_0050, 1'b0, 32'h0, 8'h00, 32'h5555_5555);
      lsu_issue(32'h1000_0050, 1'b0, 32'h0, 8'h00);
      repeat (3) @(posedge clk);
      ifu_resp_ready = 1'b0;
      exp_req_q.push_back('{lsu: 1'b0, addr: 32'h8000_0030, wen: 1'b0, wdata: 32'h0, wmask: 8'h00});
      mem_rd_q.push_back(32'h6666_6666);
      ifu_issue(32'h8000_0030);
      chk("rst_pre_resp_valid", ifu_resp_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", outs(), 6'b0);
      @(posedge clk); #1;
      rst_n          = 1'b1;
      ifu_resp_ready = 1'b1;
      expect_tx(1'b1, 32'h1000_0060, 1'b0, 32'h0, 8'h00, 32'h7777_7777);
      expect_tx(1'b0, 32'h8000_0040, 1'b0, 32'h0, 8'h00, 32'h8888_8888);
      fork
         ifu_issue(32'h8000_0040);
         lsu_issue(32'h1000_0060, 1'b0, 32'h0, 8'h00);
      join
      repeat (4) @(posedge clk);

      chk("exp_req_drained", exp_req_q.size(), 0);
      chk("exp_rsp_drained", exp_rsp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
